// File: rtl/apb_reg_slave.sv
// ---------------------------------------------------------------------------
// apb_reg_slave
//
// APB completer with a small register bank, a programmable number of wait
// states per transfer and one read-only status register that reports how
// many transfers have completed without error.
//
// Ports:
//   pclk          clock, all logic on the rising edge
//   presetn       asynchronous active-low reset
//   paddr         transfer address (ADDR_W bits)
//   pselx         slave select
//   penable       access-phase strobe
//   pwrite        1 = write, 0 = read
//   pwdata        write data (DATA_W bits)
//   pready        transfer complete (registered)
//   prdata        read data (registered)
//   pslave_error  transfer error (registered)
//   dbg_state     current FSM state (0 = IDLE, 1 = ACCESS)
//
// Handshake: a transfer starts with a setup cycle (pselx=1, penable=0) seen
// in IDLE. The access phase (pselx=1, penable=1) lasts WAIT_CYCLES+1
// cycles; pready is high during the last one and the transfer completes at
// the edge that samples pready=1 with pselx=1, penable=1. Dropping pselx
// during the access phase aborts the transfer without side effects.
// ---------------------------------------------------------------------------
module apb_reg_slave #(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 2,
    parameter int WAIT_CYCLES = 1,
    parameter int RO_ADDR     = 3
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pselx,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslave_error,
    output logic              dbg_state
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] RO    = ADDR_W'(RO_ADDR);
    localparam logic [2:0]        WC    = 3'(WAIT_CYCLES);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        wcnt, wcnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              wr_q, wr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic              pready_nxt;
    logic [DATA_W-1:0] prdata_nxt;
    logic              perr_nxt;
    logic [DATA_W-1:0] xfer_cnt, xfer_cnt_nxt;
    logic              commit;
    logic [DATA_W-1:0] bank [DEPTH];

    // Response source: with zero wait states the response is produced at the
    // setup edge, before the setup values have been latched, so it must look
    // at the live bus; otherwise it uses the latched values.
    logic [ADDR_W-1:0] resp_addr;
    logic              resp_wr;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        resp_addr = (state == IDLE) ? paddr  : addr_q;
        resp_wr   = (state == IDLE) ? pwrite : wr_q;
        resp_err  = resp_wr && (resp_addr == RO);
        if (resp_wr) begin
            resp_data = '0;
        end else if (resp_addr == RO) begin
            resp_data = xfer_cnt;
        end else begin
            resp_data = bank[resp_addr];
        end
    end

    assign dbg_state = state;

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_nxt    = state;
        wcnt_nxt     = wcnt;
        addr_nxt     = addr_q;
        wr_nxt       = wr_q;
        wdata_nxt    = wdata_q;
        pready_nxt   = pready;
        prdata_nxt   = prdata;
        perr_nxt     = pslave_error;
        xfer_cnt_nxt = xfer_cnt;
        commit       = 1'b0;

        case (state)
            IDLE: begin
                pready_nxt = 1'b0;
                prdata_nxt = '0;
                perr_nxt   = 1'b0;
                if (pselx && !penable) begin
                    addr_nxt  = paddr;
                    wr_nxt    = pwrite;
                    wdata_nxt = pwdata;
                    state_nxt = ACCESS;
                    if (WC == 3'd0) begin
                        pready_nxt = 1'b1;
                        prdata_nxt = resp_data;
                        perr_nxt   = resp_err;
                    end else begin
                        wcnt_nxt = WC;
                    end
                end
            end
            ACCESS: begin
                if (!pselx) begin
                    // Abort: nothing commits, counter untouched.
                    state_nxt  = IDLE;
                    pready_nxt = 1'b0;
                    prdata_nxt = '0;
                    perr_nxt   = 1'b0;
                end else if (penable) begin
                    if (!pready) begin
                        wcnt_nxt = wcnt - 3'd1;
                        if (wcnt == 3'd1) begin
                            pready_nxt = 1'b1;
                            prdata_nxt = resp_data;
                            perr_nxt   = resp_err;
                        end
                    end else begin
                        // Completion edge; an errored transfer has no effect.
                        if (!pslave_error) begin
                            commit       = wr_q;
                            xfer_cnt_nxt = xfer_cnt + DATA_W'(1);
                        end
                        state_nxt  = IDLE;
                        pready_nxt = 1'b0;
                        prdata_nxt = '0;
                        perr_nxt   = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers and register bank
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wcnt         <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            pready       <= 1'b0;
            prdata       <= '0;
            pslave_error <= 1'b0;
            xfer_cnt     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            wcnt         <= wcnt_nxt;
            addr_q       <= addr_nxt;
            wr_q         <= wr_nxt;
            wdata_q      <= wdata_nxt;
            pready       <= pready_nxt;
            prdata       <= prdata_nxt;
            pslave_error <= perr_nxt;
            xfer_cnt     <= xfer_cnt_nxt;
            if (commit) begin
                bank[addr_q] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_reg_slave
//
// Two instances of apb_reg_slave share the bus data signals: one with one
// wait state, one with none. Each has its own select so only the targeted
// instance sees transfers. A reference model (register array plus counter
// per instance) predicts every response.
// ---------------------------------------------------------------------------
module tb_apb_reg_slave;

    localparam int AW = 2;
    localparam int DW = 2;

    // ---------------- clock / reset ----------------
    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic          presetn;
    logic [AW-1:0] paddr;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          pselx1, pselx0;

    logic          pready1, pready0;
    logic [DW-1:0] prdata1, prdata0;
    logic          perr1, perr0;
    logic          dbg1, dbg0;

    apb_reg_slave #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1), .RO_ADDR(3)) dut1 (
        .pclk         (pclk),
        .presetn      (presetn),
        .paddr        (paddr),
        .pselx        (pselx1),
        .penable      (penable),
        .pwrite       (pwrite),
        .pwdata       (pwdata),
        .pready       (pready1),
        .prdata       (prdata1),
        .pslave_error (perr1),
        .dbg_state    (dbg1)
    );

    apb_reg_slave #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0), .RO_ADDR(3)) dut0 (
        .pclk         (pclk),
        .presetn      (presetn),
        .paddr        (paddr),
        .pselx        (pselx0),
        .penable      (penable),
        .pwrite       (pwrite),
        .pwdata       (pwdata),
        .pready       (pready0),
        .prdata       (prdata0),
        .pslave_error (perr0),
        .dbg_state    (dbg0)
    );

    // tgt selects the instance and equals its wait-state count.
    int            tgt;
    logic          o_pready;
    logic [DW-1:0] o_prdata;
    logic          o_err;

    always_comb begin
        if (tgt == 1) begin
            o_pready = pready1;
            o_prdata = prdata1;
            o_err    = perr1;
        end else begin
            o_pready = pready0;
            o_prdata = prdata0;
            o_err    = perr0;
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] bank_m [2][4];
    logic [DW-1:0] cnt_m  [2];

    function automatic void model_clear();
        for (int t = 0; t < 2; t++) begin
            cnt_m[t] = '0;
            for (int a = 0; a < 4; a++) bank_m[t][a] = '0;
        end
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s (tgt=%0d): got %0d expected %0d at %0t", tag, tgt, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_sel(input bit v);
        if (tgt == 1) pselx1 = v;
        else          pselx0 = v;
    endtask

    task automatic idle(input int n);
        set_sel(1'b0);
        penable = 1'b0;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Called #1 after an edge; the next edge is the setup edge. Returns #1
    // after the completion (or abort) edge so calls can run back-to-back.
    task automatic xfer(input bit w, input int a, input int d, input bit abort_it);
        int   waited;
        int   exp_data;
        bit   exp_err;
        exp_err  = w && (a == 3);
        exp_data = w ? 0 : ((a == 3) ? int'(cnt_m[tgt]) : int'(bank_m[tgt][a]));

        set_sel(1'b1);
        penable = 1'b0;
        pwrite  = w;
        paddr   = AW'(a);
        pwdata  = DW'(d);
        @(posedge pclk);
        #1;
        penable = 1'b1;
        // Bus contents are don't-care during the access phase.
        pwrite  = 1'($urandom_range(0, 1));
        paddr   = AW'($urandom_range(0, 3));
        pwdata  = DW'($urandom_range(0, 3));

        if (abort_it) begin
            @(negedge pclk);
            check("abort_first_access_pready", int'(o_pready), (tgt == 0) ? 1 : 0);
            set_sel(1'b0);
            @(posedge pclk);
            #1;
            penable = 1'b0;
            check("abort_pready", int'(o_pready), 0);
            check("abort_prdata", int'(o_prdata), 0);
            @(negedge pclk);
            check("abort_stays_low", int'(o_pready), 0);
            @(posedge pclk);
            #1;
            return;
        end

        @(negedge pclk);
        waited = 0;
        while (!o_pready && waited < 16) begin
            @(posedge pclk);
            @(negedge pclk);
            waited++;
        end
        check("latency", waited, tgt);
        check(w ? "wr_prdata" : "rd_prdata", int'(o_prdata), exp_data);
        check("pslave_error", int'(o_err), int'(exp_err));

        @(posedge pclk);
        #1;
        if (!exp_err) begin
            if (w) bank_m[tgt][a] = DW'(d);
            cnt_m[tgt] = cnt_m[tgt] + 2'd1;
        end
        check("done_pready", int'(o_pready), 0);
        check("done_err", int'(o_err), 0);
        set_sel(1'b0);
        penable = 1'b0;
    endtask

    // Reset with random bus activity on both instances.
    task automatic do_reset();
        presetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            paddr   = AW'($urandom_range(0, 3));
            pwdata  = DW'($urandom_range(0, 3));
            pwrite  = 1'($urandom_range(0, 1));
            penable = 1'($urandom_range(0, 1));
            pselx1  = 1'($urandom_range(0, 1));
            pselx0  = 1'($urandom_range(0, 1));
            @(negedge pclk);
            check("rst_pready1", int'(pready1), 0);
            check("rst_prdata1", int'(prdata1), 0);
            check("rst_err1",    int'(perr1), 0);
            check("rst_pready0", int'(pready0), 0);
            check("rst_state1",  int'(dbg1), 0);
        end
        pselx1  = 1'b0;
        pselx0  = 1'b0;
        penable = 1'b0;
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        model_clear();
        @(posedge pclk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tgt     = 1;
        presetn = 1'b0;
        pselx1  = 1'b0;
        pselx0  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        model_clear();

        // Reset, then reads of addr 0..2 return zero.
        do_reset();
        for (int a = 0; a < 3; a++) xfer(1'b0, a, 0, 1'b0);

        // Write/read with one wait state.
        xfer(1'b1, 1, 2, 1'b0);
        xfer(1'b0, 1, 0, 1'b0);

        // Read-only register error, then status read with a fresh counter.
        do_reset();
        xfer(1'b1, 3, 3, 1'b0);
        xfer(1'b0, 3, 0, 1'b0);

        // Counter wrap: five good writes, then two status reads.
        do_reset();
        for (int i = 0; i < 5; i++) xfer(1'b1, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        xfer(1'b0, 3, 0, 1'b0);
        xfer(1'b0, 3, 0, 1'b0);

        // Abort before pready.
        do_reset();
        xfer(1'b1, 2, 1, 1'b1);
        idle(1);
        xfer(1'b0, 2, 0, 1'b0);
        xfer(1'b0, 3, 0, 1'b0);

        // Zero wait states, back-to-back.
        tgt = 0;
        idle(1);
        xfer(1'b1, 0, 1, 1'b0);
        xfer(1'b1, 1, 2, 1'b0);
        xfer(1'b0, 0, 0, 1'b0);
        xfer(1'b0, 1, 0, 1'b0);

        // Asynchronous reset while pready is high: outputs drop at once,
        // the write is lost.
        set_sel(1'b1);
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 2'd0;
        pwdata  = 2'd3;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(negedge pclk);
        check("pre_async_pready", int'(o_pready), 1);
        presetn = 1'b0;
        #1;
        check("async_rst_pready", int'(o_pready), 0);
        check("async_rst_state", int'(dbg0), 0);
        set_sel(1'b0);
        penable = 1'b0;
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        model_clear();
        @(posedge pclk);
        #1;
        xfer(1'b0, 0, 0, 1'b0);

        // Randomized traffic on both instances.
        for (int t = 1; t >= 0; t--) begin
            tgt = t;
            idle(1);
            for (int i = 0; i < 40; i++) begin
                xfer(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
APB completer that consumes the transfers driven on the team's APB interface (paddr/pselx/penable/pwrite/pwdata) and returns pready/prdata/pslave_error.
- Implements a small register bank with programmable wait states.
- Provides one read-only status register, a completed-transfer counter; writes to it return pslave_error.
- Serves as the DUT behind the APB UVM driver/monitor.

Parameters:
ADDR_W, 2, paddr width; bank depth = 2**ADDR_W
DATA_W, 2, pwdata/prdata width
WAIT_CYCLES, 1, wait states inserted per transfer (0..7); access phase lasts WAIT_CYCLES+1 cycles
RO_ADDR, 3, address of read-only status register

Ports:
pclk  input  1  clock, all logic on rising edge
presetn  input  1  asynchronous active-low reset
paddr  input  ADDR_W  transfer address
pselx  input  1  slave select
penable  input  1  access-phase strobe
pwrite  input  1  1=write, 0=read
pwdata  input  DATA_W  write data
pready  output  1  transfer complete, registered
prdata  output  DATA_W  read data, registered
pslave_error  output  1  transfer error, registered

Behaviour:
- Reset (presetn=0, asynchronous): state=IDLE, pready=0, prdata=0, pslave_error=0, wcnt=0, xfer_cnt=0, all bank entries=0. Deassertion takes effect on the next pclk edge.
- States: IDLE, ACCESS. wcnt is 3 bits.
- IDLE, edge samples pselx=1, penable=0 (setup):
  - latch paddr/pwrite/pwdata; go to ACCESS.
  - if WAIT_CYCLES=0: pready<=1 and the response is computed at the same edge.
  - else: wcnt<=WAIT_CYCLES, pready<=0.
- IDLE, any other input (including penable=1 without a setup): no action, outputs stay 0.
- ACCESS, pready=0, edge samples pselx=1, penable=1:
  - wcnt<=wcnt-1.
  - when wcnt=1: pready<=1 and the response is computed.
- Response computation (uses the latched setup values):
  - read RO_ADDR: prdata<=xfer_cnt.
  - read other address: prdata<=bank[addr].
  - write RO_ADDR: pslave_error<=1, prdata<=0.
  - write other address: prdata<=0, pslave_error<=0.
- Completion edge (ACCESS, pready=1, pselx=1, penable=1):
  - a non-error write commits bank[addr]<=wdata.
  - a non-error transfer sets xfer_cnt<=xfer_cnt+1, wrapping mod 2**DATA_W. A status read returns the pre-increment value.
  - an error transfer changes no state.
  - pready, prdata, pslave_error<=0; state<=IDLE.
  - a back-to-back transfer must present a fresh setup phase on the next cycle.
- Abort: in ACCESS, an edge sampling pselx=0 forces IDLE, clears pready/prdata/pslave_error, commits no write, and leaves the counter unchanged.
- Latency: setup edge to pready high = WAIT_CYCLES edges after the setup edge (0 means pready is high in the first access cycle). Each transfer takes WAIT_CYCLES+2 pclk cycles including setup.
- Inputs changing mid-access are ignored; the latched setup values are used.
- Asynchronous reset mid-transfer: outputs drop immediately, the transfer is lost and no write commits.

Test Plan:
- Reset: hold presetn=0 with random bus activity -> pready=0, prdata=0, pslave_error=0; read of addr 0..2 after release -> prdata=0.
- Write/read, WAIT_CYCLES=1: write addr1 data 2'b10, then read addr1 -> pready high exactly 1 cycle after penable rises; prdata=2'b10; pslave_error=0.
- Read-only error: write addr3 data 2'b11 -> pslave_error=1 with pready. Then read addr3 -> prdata=0 (no prior good transfers, so xfer_cnt=0); pslave_error=0.
- Counter wrap: 5 good writes, then read addr3 -> prdata=5 mod 4 = 1; following read addr3 -> prdata=2.
- Abort: setup write addr2 data 2'b01, penable=1, drop pselx before pready -> no pready pulse; later read addr2 -> prdata=0; xfer_cnt unchanged.
- WAIT_CYCLES=0 back-to-back: alternating setup/access of writes addr0=1, addr1=2, then reads -> pready high on every access cycle; reads return 1 and 2.
